seq_monitor: RTL and testbench
==============================

# seq_monitor

Downstream consumer of the single-bit output of the JK-flip-flop sequence generator. Samples that waveform on the same clock, measures high-run, low-run and period lengths in clock cycles, and locks once the period repeats consistently. After lock it flags any deviation as an error, and it flags a stuck line. Its outputs feed the lab board's LEDs and the self-check bench.

## Interface
- CNT_W, 8: width of the run-length counters; max measurable run is 2^CNT_W-1 cycles.
- LOCK_PERIODS, 2: consecutive matching periods required before `locked` asserts; range 1..15.
- clck  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high. One clock, no other clock domains.
- din  in  1  sequence-generator output, already synchronous to `clck`.
- rise_pulse  out  1  one-cycle pulse per detected rising edge of `din`; reset 0.
- high_len  out  CNT_W  length of the last completed high run; reset 0.
- low_len  out  CNT_W  length of the last completed low run; reset 0.
- period  out  CNT_W+1  length of the last completed period (low run + preceding high run), updated on each rise; reset 0.
- locked  out  1  level; reset 0.
- err  out  1  one-cycle pulse on a mismatch while locked; reset 0.
- stuck  out  1  level, set on run-counter saturation; reset 0.

## Operation
- Registers:
  - `din_q`: previous sample, reset 0.
  - `run_cnt`: cycles in the current run, reset 0.
  - `ref_period`: reset 0.
  - `match_cnt`: reset 0.
- Each edge, same value (`din == din_q`): `run_cnt` <= saturating `run_cnt+1`.
- Each edge, transition (`din != din_q`): `run_cnt` <= 1.
  - If `din_q` was 1: `high_len` <= `run_cnt`.
  - If `din_q` was 0: `low_len` <= `run_cnt`, `period` <= `run_cnt + high_len`, and `rise_pulse` <= 1.
- Period arithmetic is unsigned, CNT_W+1 bits, so it cannot overflow.
- FSM states: IDLE, ARM, LOCKING, LOCKED.
  - IDLE: on a rise, go to ARM. The pre-reset partial low run is discarded.
  - ARM: on a rise, the period is now valid. Set `ref_period` <= new period, `match_cnt` <= 0, go to LOCKING.
  - LOCKING, rise with period == `ref_period`: `match_cnt`+1. When it reaches LOCKING_PERIODS (LOCK_PERIODS), go to LOCKED and set `locked` <= 1.
  - LOCKING, rise with a mismatch: `ref_period` <= new period, `match_cnt` <= 0, stay in LOCKING.
  - LOCKED, rise with a mismatch: `err` pulse, `locked` <= 0, `ref_period` <= new period, `match_cnt` <= 0, go to LOCKING.
- Stuck detection, any state other than IDLE: if `run_cnt` reaches 2^CNT_W-1, set `stuck` <= 1, `locked` <= 0, go to IDLE.
  - `stuck` clears on the next rise.
  - `high_len`, `low_len` and `period` hold their last values.
- Reset mid-operation: every register returns to its reset value on the next edge. The first rise after reset only arms the FSM.

## Timing
- Latency: a rise of `din` sampled at edge k gives `rise_pulse`, `period`, `low_len` and the FSM update visible after edge k (one cycle); `high_len` updates after the falling-edge sample.
- `locked` asserts after the edge that samples the (2+LOCK_PERIODS)th rise since IDLE.
- `err` is high for exactly one cycle and never coincides with `locked` = 1 in the following cycle.
- Reset dominates: if `rst` and a transition arrive at the same edge, the transition is lost.
- Runs of length 1 are measured correctly (1-cycle high gives `high_len` = 1).

## Configuration
- SEQ_MONITOR_DUTY_EN defined:
  - The LOCKING/LOCKED match compares both `period` and `high_len` against stored references.
  - A `ref_high` register is added and loaded alongside `ref_period`.
- Not defined: only `period` is compared, and `ref_high` does not exist. Port list identical in both builds.

## Structure
- Package `seq_mon_pkg`: FSM state enum (IDLE, ARM, LOCKING, LOCKED), default CNT_W, and a saturating-max constant function of CNT_W.
- Sub-module `edge_run_counter`: owns `din_q`, `run_cnt`, edge detection, saturation, `high_len`/`low_len`/`period` capture. It exports `rise`, `fall` and `sat` strobes.
- `seq_monitor` holds the FSM, the references, the match counter and the output flags.

## Test plan
- `rst` for 2 cycles, then `din` = 0 → all outputs 0; `stuck` = 1 never, because the FSM stays in IDLE.
- Repeating high 2 / low 3, LOCK_PERIODS=2 → after each rise, `period` = 5, `high_len` = 2, `low_len` = 3; `locked` = 1 after the 4th rise; `err` never.
- Locked, then one period of high 2 / low 4 → `err` 1 for one cycle, `locked` 0, `period` = 6. The pattern then returns to 5, mismatches once, and relocks after 2 further matching periods.
- Locked, then `din` held 1 for 255 cycles (CNT_W=8) → `stuck` = 1, `locked` = 0; the next rise clears `stuck`, and the FSM goes to ARM.
- With SEQ_MONITOR_DUTY_EN: locked on 2/3, switch to 1/4 (period still 5) → `err` pulse. Without the macro → no `err`.
- `rst` asserted mid-lock for 1 cycle → next cycle: `locked` = 0, `period` = 0, `run_cnt` = 0, FSM in IDLE. Relock needs 4 rises.

Source files
------------

// File: rtl/seq_mon_pkg.sv
// Shared types and constants for the sequence-generator monitor.
// The SEQ_MONITOR_DUTY_EN build option is consumed by seq_monitor.sv.
package seq_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        LOCKING,
        LOCKED
    } state_t;

    localparam int CNT_W_DEF = 8;

    function automatic int unsigned sat_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/edge_run_counter.sv
// Edge detector and saturating run-length counter for the monitored line.
// Captures completed high/low run lengths and the rise-to-rise period.
module edge_run_counter
    import seq_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_din,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_sat,
    output logic [CNT_W-1:0] o_high_len,
    output logic [CNT_W-1:0] o_low_len,
    output logic [CNT_W:0]   o_period,
    output logic [CNT_W:0]   o_new_period
);

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(sat_max(CNT_W));

    logic             r_din_q;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] r_high_len;
    logic [CNT_W-1:0] r_low_len;
    logic [CNT_W:0]   r_period;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W:0]   w_new_period;

    assign w_rise       = i_din & ~r_din_q;
    assign w_fall       = ~i_din & r_din_q;
    // One extra bit so the sum of two saturated runs still fits.
    assign w_new_period = {1'b0, r_run_cnt} + {1'b0, r_high_len};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_q    <= 1'b0;
            r_run_cnt  <= '0;
            r_high_len <= '0;
            r_low_len  <= '0;
            r_period   <= '0;
        end else begin
            r_din_q <= i_din;
            if (w_rise || w_fall) begin
                r_run_cnt <= CNT_W'(1);
                if (r_din_q) begin
                    r_high_len <= r_run_cnt;
                end else begin
                    r_low_len <= r_run_cnt;
                    r_period  <= w_new_period;
                end
            end else if (r_run_cnt != RUN_MAX) begin
                r_run_cnt <= r_run_cnt + CNT_W'(1);
            end
        end
    end

    assign o_rise       = w_rise;
    assign o_fall       = w_fall;
    assign o_sat        = (r_run_cnt == RUN_MAX);
    assign o_high_len   = r_high_len;
    assign o_low_len    = r_low_len;
    assign o_period     = r_period;
    assign o_new_period = w_new_period;

endmodule

// File: rtl/seq_monitor.sv
// Period-lock monitor for the JK sequence generator output: lock, error and stuck flags.
// Define SEQ_MONITOR_DUTY_EN to also require the high-run length to match after lock.
module seq_monitor
    import seq_mon_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int LOCK_PERIODS = 2
) (
    input  logic             clck,
    input  logic             rst,
    input  logic             din,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W:0]   period,
    output logic             locked,
    output logic             err,
    output logic             stuck
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_PERIODS);

    logic           w_rise;
    logic           w_fall;
    logic           w_sat;
    logic           w_stuck_evt;
    logic           w_match;
    logic           w_load;
    logic [CNT_W:0] w_new_period;

    state_t         r_state;
    logic [CNT_W:0] r_ref_period;
    logic [3:0]     r_match_cnt;
    logic           r_rise_pulse;
    logic           r_locked;
    logic           r_err;
    logic           r_stuck;

    edge_run_counter #(.CNT_W(CNT_W)) u_run (
        .clk          (clck),
        .rst          (rst),
        .i_din        (din),
        .o_rise       (w_rise),
        .o_fall       (w_fall),
        .o_sat        (w_sat),
        .o_high_len   (high_len),
        .o_low_len    (low_len),
        .o_period     (period),
        .o_new_period (w_new_period)
    );

    // A run that ends exactly at the counter limit is still a valid measurement.
    assign w_stuck_evt = w_sat && !(w_rise || w_fall) && (r_state != IDLE);

`ifdef SEQ_MONITOR_DUTY_EN
    logic [CNT_W-1:0] r_ref_high;

    assign w_match = (w_new_period == r_ref_period) && (high_len == r_ref_high);

    always_ff @(posedge clck) begin
        if (rst) begin
            r_ref_high <= '0;
        end else if (w_load) begin
            r_ref_high <= high_len;
        end
    end
`else
    assign w_match = (w_new_period == r_ref_period);
`endif

    assign w_load = w_rise && !w_stuck_evt &&
                    ((r_state == ARM) ||
                     (((r_state == LOCKING) || (r_state == LOCKED)) && !w_match));

    always_ff @(posedge clck) begin
        if (rst) begin
            r_ref_period <= '0;
        end else if (w_load) begin
            r_ref_period <= w_new_period;
        end
    end

    always_ff @(posedge clck) begin
        if (rst) begin
            r_state      <= IDLE;
            r_match_cnt  <= '0;
            r_rise_pulse <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_err        <= 1'b0;
            r_rise_pulse <= w_rise;
            if (w_stuck_evt) begin
                r_stuck  <= 1'b1;
                r_locked <= 1'b0;
                r_state  <= IDLE;
            end else if (w_rise) begin
                r_stuck <= 1'b0;
                case (r_state)
                    IDLE: r_state <= ARM;
                    ARM: begin
                        r_match_cnt <= '0;
                        r_state     <= LOCKING;
                    end
                    LOCKING: begin
                        if (w_match) begin
                            r_match_cnt <= r_match_cnt + 4'd1;
                            if (r_match_cnt + 4'd1 == LOCK_N) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!w_match) begin
                            r_err       <= 1'b1;
                            r_locked    <= 1'b0;
                            r_match_cnt <= '0;
                            r_state     <= LOCKING;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign rise_pulse = r_rise_pulse;
    assign locked     = r_locked;
    assign err        = r_err;
    assign stuck      = r_stuck;

endmodule

// File: tb/tb_seq_monitor.sv
// Self-checking bench for seq_monitor: directed lock/err/stuck/reset scenarios plus random
// waveforms, all compared each cycle against a history-based model of the lock rules.
module tb_seq_monitor;

    localparam int CNT_W        = 8;
    localparam int LOCK_PERIODS = 2;
    localparam int RUN_MAX      = 255;
`ifdef SEQ_MONITOR_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din = 1'b0;
    logic             rise_pulse;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W:0]   period;
    logic             locked;
    logic             err;
    logic             stuck;

    always #5 clk = ~clk;

    seq_monitor #(.CNT_W(CNT_W), .LOCK_PERIODS(LOCK_PERIODS)) dut (
        .clck       (clk),
        .rst        (rst),
        .din        (din),
        .rise_pulse (rise_pulse),
        .high_len   (high_len),
        .low_len    (low_len),
        .period     (period),
        .locked     (locked),
        .err        (err),
        .stuck      (stuck)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: measured runs plus the history of period keys seen since the monitor last armed.
    // Locked means the newest LOCK_PERIODS+1 keys are identical.
    int m_prev, m_run, m_high, m_low, m_period;
    int m_rise, m_locked, m_err, m_stuck;
    int m_rises;
    int hist[$];
    bit m_valid = 1'b0;

    function automatic int trailing_equal();
        int c = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size() - 1]) c++;
            else break;
        end
        return c;
    endfunction

    always @(posedge clk) begin : model
        int run_old, prev_old, np, key;
        bit tr, rise;
        if (rst) begin
            m_prev = 0; m_run = 0; m_high = 0; m_low = 0; m_period = 0;
            m_rise = 0; m_locked = 0; m_err = 0; m_stuck = 0; m_rises = 0;
            hist.delete();
            m_valid = 1'b1;
        end else begin
            run_old  = m_run;
            prev_old = m_prev;
            np       = m_run + m_high;
            tr       = (int'(din) != m_prev);
            rise     = din && (m_prev == 0);
            m_err    = 0;
            m_rise   = rise;
            if (m_rises > 0 && run_old == RUN_MAX && !tr) begin
                m_stuck  = 1;
                m_locked = 0;
                m_rises  = 0;
                hist.delete();
            end else if (rise) begin
                m_stuck = 0;
                if (m_rises > 0) begin
                    key = DUTY ? (np * 4096 + m_high) : np;
                    if (hist.size() > 0 && key != hist[$] && m_locked != 0) m_err = 1;
                    hist.push_back(key);
                    if (hist.size() > 64) void'(hist.pop_front());
                    m_locked = (trailing_equal() > LOCK_PERIODS) ? 1 : 0;
                end
                m_rises++;
            end
            if (tr) begin
                m_run = 1;
                if (prev_old != 0) m_high = run_old;
                else begin
                    m_low    = run_old;
                    m_period = np;
                end
            end else if (m_run < RUN_MAX) begin
                m_run++;
            end
            m_prev = din;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("rise_pulse", rise_pulse, m_rise);
            check("high_len",   high_len,   m_high);
            check("low_len",    low_len,    m_low);
            check("period",     period,     m_period);
            check("locked",     locked,     m_locked);
            check("err",        err,        m_err);
            check("stuck",      stuck,      m_stuck);
        end
    end

    task automatic cyc(input bit d);
        din = d;
        @(negedge clk);
    endtask

    task automatic pat(input int h, input int l);
        repeat (h) cyc(1'b1);
        repeat (l) cyc(1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    initial begin
        int h, l, reps;
        rst = 1'b1;
        repeat (2) cyc(1'b0);
        rst = 1'b0;
        cyc(1'b0);
        check("lit_reset_locked", locked, 0);
        check("lit_reset_period", period, 0);
        check("lit_reset_rise",   rise_pulse, 0);
        repeat (300) cyc(1'b0);
        check("lit_idle_no_stuck", stuck, 0);

        // Lock on high 2 / low 3
        repeat (3) pat(2, 3);
        check("lit_not_locked_3rises", locked, 0);
        cyc(1'b1);
        check("lit_lock_rise",   rise_pulse, 1);
        check("lit_lock_period", period, 5);
        check("lit_lock_low",    low_len, 3);
        check("lit_lock_high",   high_len, 2);
        check("lit_locked_4th",  locked, 1);
        cyc(1'b1);
        repeat (3) cyc(1'b0);

        // One long period while locked
        pat(2, 4);
        cyc(1'b1);
        check("lit_err_pulse",  err, 1);
        check("lit_err_unlock", locked, 0);
        check("lit_err_period", period, 6);
        cyc(1'b1);
        check("lit_err_one_cycle", err, 0);
        repeat (3) cyc(1'b0);
        repeat (2) pat(2, 3);
        check("lit_relock_pending", locked, 0);
        cyc(1'b1);
        check("lit_relocked", locked, 1);

        // Stuck high while locked
        repeat (300) cyc(1'b1);
        check("lit_stuck_set",    stuck, 1);
        check("lit_stuck_unlock", locked, 0);
        cyc(1'b0);
        cyc(1'b1);
        check("lit_stuck_clear", stuck, 0);
        cyc(1'b1);
        repeat (3) cyc(1'b0);

        // Duty change at constant period
        repeat (3) pat(2, 3);
        check("lit_duty_locked", locked, 1);
        pat(1, 4);
        cyc(1'b1);
        check("lit_duty_err", err, DUTY ? 1 : 0);
        check("lit_duty_period", period, 5);
        repeat (4) cyc(1'b0);
        repeat (4) pat(1, 4);

        // Reset in the middle of lock
        repeat (4) pat(3, 2);
        check("lit_pre_reset_locked", locked, 1);
        rst = 1'b1;
        cyc(1'b1);
        rst = 1'b0;
        check("lit_midrst_locked", locked, 0);
        check("lit_midrst_period", period, 0);
        check("lit_midrst_high",   high_len, 0);
        cyc(1'b0);
        repeat (3) pat(3, 2);
        check("lit_midrst_3rises", locked, 0);
        cyc(1'b1);
        check("lit_midrst_relock", locked, 1);
        cyc(1'b1);
        cyc(1'b1);
        repeat (2) cyc(1'b0);

        // Random waveforms, occasional resets and long runs near saturation
        for (int it = 0; it < 150; it++) begin
            h    = $urandom_range(1, 4);
            l    = $urandom_range(1, 4);
            reps = $urandom_range(1, 5);
            repeat (reps) pat(h, l);
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                cyc($urandom_range(0, 1) == 1);
                rst = 1'b0;
            end
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(250, 260)) cyc(1'b1);
                cyc(1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
